// File: rtl/hybrid_lane_pipe.sv
// Multi-lane NAND-mixing pipeline with valid/ready back-pressure and a wrapping transfer counter.
// Define HYBRID_PIPE_PARITY_EN to add the per-lane out_parity output.
module hybrid_lane_pipe #(
    parameter int WIDTH  = 4,
    parameter int LANES  = 2,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       out_count
`ifdef HYBRID_PIPE_PARITY_EN
    ,
    output logic [LANES-1:0]       out_parity
`endif
);

    localparam int DW = LANES * WIDTH;

    logic          vld_p  [1:STAGES];
    logic [DW-1:0] data_p [1:STAGES];
    logic          vld_in [1:STAGES];
    logic [DW-1:0] data_in[1:STAGES];
    logic          adv    [1:STAGES+1];
    logic [CNT_W-1:0] count;

    // Each lane is NANDed with its upper neighbour; the top lane wraps to lane 0.
    function automatic logic [DW-1:0] mix(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*WIDTH +: WIDTH] = ~(x[i*WIDTH +: WIDTH] & x[((i + 1) % LANES)*WIDTH +: WIDTH]);
        end
        return r;
    endfunction

    always_comb begin
        for (int s = 1; s <= STAGES + 1; s++) begin
            adv[s] = 1'b0;
        end
        adv[STAGES+1] = out_ready;
        for (int s = STAGES; s >= 1; s--) begin
            adv[s] = ~vld_p[s] | adv[s+1];
        end
    end

    always_comb begin
        vld_in[1]  = in_valid;
        data_in[1] = in_data;
        for (int s = 2; s <= STAGES; s++) begin
            vld_in[s]  = vld_p[s-1];
            data_in[s] = data_p[s-1];
        end
    end

    // Stage boundaries: every stage loads from its predecessor when its slot frees up.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= STAGES; s++) begin
                vld_p[s]  <= 1'b0;
                data_p[s] <= '0;
            end
            count <= '0;
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                if (adv[s]) begin
                    vld_p[s] <= vld_in[s];
                    if (vld_in[s]) begin
                        data_p[s] <= mix(data_in[s]);
                    end
                end
            end
            if (vld_p[STAGES] && out_ready) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign in_ready  = adv[1];
    assign out_valid = vld_p[STAGES];
    assign out_data  = data_p[STAGES];
    assign out_count = count;

`ifdef HYBRID_PIPE_PARITY_EN
    always_comb begin
        out_parity = '0;
        for (int i = 0; i < LANES; i++) begin
            out_parity[i] = ^data_p[STAGES][i*WIDTH +: WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_hybrid_lane_pipe.sv
// Scoreboard bench for hybrid_lane_pipe: accepted beats push model results, a monitor pops on output transfers.
module tb_hybrid_lane_pipe;

    localparam int WIDTH  = 4;
    localparam int LANES  = 2;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;
    localparam int DW     = WIDTH * LANES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CNT_W-1:0] out_count;
`ifdef HYBRID_PIPE_PARITY_EN
    logic [LANES-1:0] out_parity;
`endif

    hybrid_lane_pipe #(
        .WIDTH(WIDTH), .LANES(LANES), .STAGES(STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_count(out_count)
`ifdef HYBRID_PIPE_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;
    int n_acc    = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: lanes as integers, NAND with the next lane, repeated once per stage.
    function automatic logic [DW-1:0] ref_model(input logic [DW-1:0] x);
        int lane[LANES];
        int nxt[LANES];
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) lane[i] = int'(x[i*WIDTH +: WIDTH]);
        repeat (STAGES) begin
            for (int i = 0; i < LANES; i++)
                nxt[i] = (~(lane[i] & lane[(i + 1) % LANES])) & ((1 << WIDTH) - 1);
            lane = nxt;
        end
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = WIDTH'(lane[i]);
        return r;
    endfunction

    function automatic logic [LANES-1:0] ref_parity(input logic [DW-1:0] x);
        logic [LANES-1:0] p;
        p = '0;
        for (int i = 0; i < LANES; i++) p[i] = ^x[i*WIDTH +: WIDTH];
        return p;
    endfunction

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(ref_model(in_data));
            n_acc++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            n_xfer = 0;
        end else begin
            check("out_count", 64'(out_count), 64'(n_xfer % (1 << CNT_W)));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q[0]));
`ifdef HYBRID_PIPE_PARITY_EN
                    check("out_parity", 64'(out_parity), 64'(ref_parity(exp_q[0])));
`endif
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        // Reset held with traffic on the inputs
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hAB;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_out_count", 64'(out_count), 64'd0);
        end
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_data", 64'(out_data), 64'd0);

        // Single beat: lane0=F, lane1=3
        step();
        in_valid = 1'b1; in_data = {4'h3, 4'hF};
        step();
        in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        check("single_early_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'h33);
`ifdef HYBRID_PIPE_PARITY_EN
        check("single_parity", 64'(out_parity), 64'd0);
`endif
        step();
        @(negedge clk);
        check("single_count", 64'(out_count), 64'd1);

        // Streaming 20 beats with the sink always ready
        step();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            @(negedge clk);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        repeat (STAGES + 1) step();
        @(negedge clk);
        check("stream_xfers", 64'(n_xfer), 64'd21);
        check("stream_count", 64'(out_count), 64'(21 % 16));

        // Back-pressure on an empty pipe
        step();
        out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            step();
        end
        @(negedge clk);
        check("bp_accepts", 64'(n_acc - acc0), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        drain("bp_drain");

        // Randomised valid/ready traffic
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain("rand_drain");

        // Reset with two beats in flight
        in_valid = 1'b1; in_data = DW'($urandom);
        step();
        in_data = DW'($urandom);
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(out_count), 64'd0);
        repeat (5) begin
            step();
            @(negedge clk);
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        // Counter wrap: 17 transfers on a 4-bit counter
        step();
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        drain("wrap_drain");
        step();
        @(negedge clk);
        check("wrap_count", 64'(out_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hybrid_lane_pipe.md
# hybrid_lane_pipe

Parametrised multi-lane NAND-mixing pipeline used as a placement and floorplan test design for hybrid-row libraries. LANES data lanes of WIDTH bits each pass through STAGES registered mixing stages; every stage cross-couples each lane with its neighbour through a bitwise NAND. A valid/ready handshake supports back-pressure, and a transfer counter gives benches and timing flows a deterministic observable.

## Interface
- WIDTH, 4, bits per lane (≥1)
- LANES, 2, number of lanes (≥2)
- STAGES, 2, number of registered mixing stages (≥1)
- CNT_W, 16, width of transfer counter

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  pipeline accepts input this cycle
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  output beat present
- out_ready  in  1  sink accepts output this cycle
- out_data  out  LANES*WIDTH  mixed result, same lane packing
- out_count  out  CNT_W  number of completed output transfers, wrapping
- out_parity  out  LANES  per-lane XOR reduction of out_data (only with HYBRID_PIPE_PARITY_EN)

## Operation
- Stage s (1..STAGES) holds a valid bit v[s] and a LANES*WIDTH data register d[s].
- Mixing function into stage s from x (in_data for s=1, d[s-1] otherwise): lane i = ~(x[i] & x[(i+1) mod LANES]), bitwise.
- Stage s advances when a[s] = ~v[s] | a[s+1]; a[STAGES+1] = out_ready. in_ready = a[1].
- On advance: v[s] <= v[s-1] (in_valid for s=1); d[s] loads mixed data only when the incoming valid is 1, else holds.
- Stage not advancing holds v[s] and d[s] unchanged (no data loss, no duplication).
- out_valid = v[STAGES]; out_data = d[STAGES].
- out_count increments by 1 on each cycle with out_valid & out_ready; wraps from 2^CNT_W−1 to 0.
- in_ready and out_valid are functions of registered state and out_ready only; in_ready may depend combinationally on out_ready (full-throughput chain).
- Reset: all v[s] = 0, all d[s] = 0, out_count = 0; hence out_valid = 0, out_data = 0, in_ready = 1 in the cycle after reset deasserts (in_ready = 1 also while rst is high). out_parity reset value 0.
- Reset mid-operation discards all in-flight beats; in_valid during rst is ignored; out_ready during rst does not increment out_count.

## Timing
- Latency: beat accepted at edge k appears on out_valid after edge k+STAGES−1 (visible in cycle k+STAGES) when not stalled.
- Throughput: one beat per cycle with out_ready held high.
- Stall: out_ready low with all stages full ⇒ in_ready low same cycle; release restores in_ready same cycle.
- Simultaneous in accept and out transfer on a full pipe: both occur, occupancy unchanged.
- Bubbles: non-full pipe accepts input while out_ready low, filling empty stages.

## Configuration
- HYBRID_PIPE_PARITY_EN defined: out_parity port present; out_parity[i] = ^out_data lane i, combinational from d[STAGES], 0 after reset.
- Undefined: out_parity port and logic absent; all other behaviour identical.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1, out_ready=1 → out_valid=0, out_data=0, out_count=0, in_ready=1 throughout and one cycle after.
- Single beat (defaults): in_data lane0=0xF, lane1=0x3 → out_data lane0=0x3, lane1=0x3 exactly 2 cycles later; out_count=1; parity (if enabled) = 2'b00.
- Streaming: 20 consecutive beats, out_ready=1 → 20 outputs on consecutive cycles matching reference model, in_ready never low, out_count=20.
- Back-pressure: fill pipe, out_ready=0 for 5 cycles → in_ready=0 after 2 accepts, out_data stable; then out_ready=1 → no drop/duplicate, order preserved.
- Counter wrap: CNT_W=4, 17 transfers → out_count=1.
- Mid-stream reset: 2 beats in flight, assert rst 1 cycle → out_valid=0 next cycle, no stale beat emerges later, out_count=0.
